// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO: configurable data width and oversampling,
// runtime parity (none/even/odd) and one or two stop bits, latched per frame.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_tick,
    input  logic [DATA_WIDTH-1:0]              i_data,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [1:0]                         i_parity_mode,
    input  logic                               i_stop2,
    output logic                               o_tx,
    output logic                               o_busy,
    output logic                               o_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W  = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_next;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    state_t                state;
    state_t                state_next;

    assign push = i_valid && o_ready;
    assign pop  = (state == S_IDLE) && (o_fifo_count != '0);
    assign head = mem[rd_ptr];

    always_comb begin
        count_next = o_fifo_count;
        if (push && !pop) begin
            count_next = o_fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = o_fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_count <= '0;
            o_ready      <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_fifo_count <= count_next;
            o_ready      <= (count_next < CNT_W'(FIFO_DEPTH));
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Transmit state machine
    // ------------------------------------------------------------------
    logic [TICK_W-1:0]     tick_cnt;
    logic [TICK_W-1:0]     tick_next;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      bit_next;
    logic                  stop_idx;
    logic                  stop_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  par_en;
    logic                  par_en_next;
    logic                  par_bit;
    logic                  par_bit_next;
    logic                  stop2_lat;
    logic                  stop2_next;
    logic                  tx_next;
    logic                  busy_next;
    logic                  done_next;
    logic                  bit_end;

    assign bit_end = i_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift_reg <= '0;
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
            stop2_lat <= 1'b0;
            o_tx      <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_next;
            bit_idx   <= bit_next;
            stop_idx  <= stop_next;
            shift_reg <= shift_next;
            par_en    <= par_en_next;
            par_bit   <= par_bit_next;
            stop2_lat <= stop2_next;
            o_tx      <= tx_next;
            o_busy    <= busy_next;
            o_done    <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        tick_next    = tick_cnt;
        bit_next     = bit_idx;
        stop_next    = stop_idx;
        shift_next   = shift_reg;
        par_en_next  = par_en;
        par_bit_next = par_bit;
        stop2_next   = stop2_lat;
        tx_next      = o_tx;
        done_next    = 1'b0;

        if ((state != S_IDLE) && i_tick) begin
            tick_next = bit_end ? '0 : tick_cnt + TICK_W'(1);
        end

        unique case (state)
            S_IDLE: begin
                tx_next = 1'b1;
                // Frame config and parity are captured at pop so later changes cannot disturb it.
                if (pop) begin
                    shift_next   = head;
                    par_en_next  = (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
                    par_bit_next = (^head) ^ i_parity_mode[1];
                    stop2_next   = i_stop2;
                    state_next   = S_START;
                    tick_next    = '0;
                    tx_next      = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next = S_DATA;
                    bit_next   = '0;
                    tx_next    = shift_reg[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx < IDX_W'(DATA_WIDTH - 1)) begin
                        bit_next   = bit_idx + IDX_W'(1);
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_reg[1];
                    end else if (par_en) begin
                        state_next = S_PARITY;
                        tx_next    = par_bit;
                    end else begin
                        state_next = S_STOP;
                        stop_next  = 1'b0;
                        tx_next    = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                    stop_next  = 1'b0;
                    tx_next    = 1'b1;
                end
            end
            S_STOP: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    if (stop2_lat && !stop_idx) begin
                        stop_next = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

endmodule
